// File: rtl/fp_accum_pkg.sv
// rtl/fp_accum_pkg.sv - shared fp32 type and constants for the channel accumulator
package fp_accum_pkg;

    typedef logic [31:0] fp32_t;

    localparam fp32_t FP_POS_ZERO = 32'h0000_0000;
    localparam fp32_t FP_NEG_ZERO = 32'h8000_0000;
    localparam fp32_t FP_QNAN     = 32'hFFC0_0000;
    localparam fp32_t FP_QUIET    = 32'h0040_0000;

endpackage

// File: rtl/floating_point_add.sv
// rtl/floating_point_add.sv - IEEE-754 single-precision adder, round-to-nearest-even, valid-tagged pipeline
module floating_point_add
    import fp_accum_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_tvalid,
    input  fp32_t            op_a,
    input  fp32_t            op_b,
    input  logic [TAG_W-1:0] op_tuser,
    output logic             res_tvalid,
    output fp32_t            res_tdata,
    output logic [TAG_W-1:0] res_tuser
);

    // Full-precision add in one combinational step; the pipeline registers
    // behind it only carry the result and its tag for LATENCY edges.
    function automatic fp32_t fp_add(input fp32_t a, input fp32_t b);
        fp32_t       x;
        fp32_t       y;
        logic [9:0]  ex;
        logic [9:0]  ey;
        logic [9:0]  e;
        logic [9:0]  diff;
        logic [23:0] mx;
        logic [23:0] my;
        logic [26:0] xe;
        logic [26:0] ye;
        logic [26:0] ysh;
        logic [26:0] m;
        logic [27:0] sum;
        logic [24:0] mant;
        logic        sticky;
        logic        rnd_up;
        logic        a_nan;
        logic        b_nan;
        logic        a_inf;
        logic        b_inf;

        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

        if (a_nan) return a | FP_QUIET;
        if (b_nan) return b | FP_QUIET;
        if (a_inf && b_inf) return (a[31] != b[31]) ? FP_QNAN : a;
        if (a_inf) return a;
        if (b_inf) return b;

        // x carries the larger magnitude, so the difference never goes negative
        if (b[30:0] > a[30:0]) begin
            x = b;
            y = a;
        end else begin
            x = a;
            y = b;
        end

        // subnormals use exponent 1 with no hidden bit
        ex = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
        ey = (y[30:23] == 8'd0) ? 10'd1 : {2'b00, y[30:23]};
        mx = {x[30:23] != 8'd0, x[22:0]};
        my = {y[30:23] != 8'd0, y[22:0]};

        // three extra low bits: guard, round, sticky
        xe   = {mx, 3'b000};
        ye   = {my, 3'b000};
        diff = ex - ey;
        if (diff >= 10'd27) begin
            ysh = {26'd0, ye != 27'd0};
        end else begin
            ysh    = ye >> diff;
            sticky = (ye & ((27'd1 << diff) - 27'd1)) != 27'd0;
            ysh[0] = ysh[0] | sticky;
        end

        if (x[31] == y[31]) sum = {1'b0, xe} + {1'b0, ysh};
        else                sum = {1'b0, xe} - {1'b0, ysh};

        // exact cancellation gives +0 unless both inputs were -0
        if (sum == 28'd0) return {x[31] & y[31], 31'd0};

        e = ex;
        if (sum[27]) begin
            m = sum[27:1] | {26'd0, sum[0]};
            e = e + 10'd1;
        end else begin
            m = sum[26:0];
            // normalise left, stopping at the subnormal exponent
            for (int i = 0; i < 26; i++) begin
                if (!m[26] && (e > 10'd1)) begin
                    m = m << 1;
                    e = e - 10'd1;
                end
            end
        end

        rnd_up = m[2] && (m[1] || m[0] || m[3]);
        mant   = {1'b0, m[26:3]} + {24'd0, rnd_up};
        if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 10'd1;
        end

        if (e >= 10'd255) return {x[31], 8'hFF, 23'd0};
        // a subnormal that rounds up into the hidden bit becomes exponent 1 naturally
        return {x[31], (mant[23] ? e[7:0] : 8'd0), mant[22:0]};
    endfunction

    fp32_t            sum_comb;
    logic             stage_valid [LATENCY];
    fp32_t            stage_data  [LATENCY];
    logic [TAG_W-1:0] stage_tag   [LATENCY];

    always_comb begin
        sum_comb = fp_add(op_a, op_b);
    end

    always_ff @(posedge clk) begin
        stage_valid[0] <= op_tvalid;
        stage_data[0]  <= sum_comb;
        stage_tag[0]   <= op_tuser;
        for (int i = 1; i < LATENCY; i++) begin
            stage_valid[i] <= stage_valid[i-1];
            stage_data[i]  <= stage_data[i-1];
            stage_tag[i]   <= stage_tag[i-1];
        end
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_valid[i] <= 1'b0;
            end
        end
    end

    assign res_tvalid = stage_valid[LATENCY-1];
    assign res_tdata  = stage_data[LATENCY-1];
    assign res_tuser  = stage_tag[LATENCY-1];

endmodule

// File: rtl/fp_channel_accumulate.sv
// rtl/fp_channel_accumulate.sv - multi-channel fp32 running-sum accumulator around a pipelined adder
module fp_channel_accumulate
    import fp_accum_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int ADD_LATENCY  = 3,
    localparam int CHAN_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic              clkIn,
    input  logic              rstIn,
    input  logic              validIn,
    output logic              readyOut,
    input  logic              startIn,
    input  logic              lastIn,
    input  logic [CHAN_W-1:0] chanIn,
    input  logic [31:0]       dataIn,
    output logic              validOut,
    output logic [CHAN_W-1:0] chanOut,
    output logic [31:0]       dataOut,
    output logic [15:0]       countOut
);

    localparam int TAG_W = CHAN_W + 2;

    fp32_t             acc [NUM_CHANNELS];
    logic [15:0]       cnt [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] busy;

    logic              chan_ok;
    logic              accept;
    fp32_t             operand_b;
    logic [TAG_W-1:0]  op_tag;

    logic              res_valid;
    fp32_t             res_data;
    logic [TAG_W-1:0]  res_tag;
    logic [CHAN_W-1:0] wb_chan;
    logic              wb_start;
    logic              wb_last;
    logic [15:0]       cnt_next;

    logic              out_pending;
    logic [CHAN_W-1:0] pend_chan;
    fp32_t             pend_data;
    logic [15:0]       pend_count;

    // A channel index beyond NUM_CHANNELS is never accepted, so the register
    // arrays are never addressed out of range.
    always_comb begin
        chan_ok   = int'(chanIn) < NUM_CHANNELS;
        readyOut  = rstIn || (chan_ok && !busy[chanIn]);
        accept    = validIn && readyOut && !rstIn;
        // -0.0 is the additive identity that leaves every sample bit-exact
        operand_b = startIn ? FP_NEG_ZERO : acc[chanIn];
        op_tag    = {chanIn, startIn, lastIn};
    end

    floating_point_add #(
        .LATENCY (ADD_LATENCY),
        .TAG_W   (TAG_W)
    ) u_add (
        .clk        (clkIn),
        .rst        (rstIn),
        .op_tvalid  (accept),
        .op_a       (dataIn),
        .op_b       (operand_b),
        .op_tuser   (op_tag),
        .res_tvalid (res_valid),
        .res_tdata  (res_data),
        .res_tuser  (res_tag)
    );

    always_comb begin
        {wb_chan, wb_start, wb_last} = res_tag;
        if (wb_start)                       cnt_next = 16'd1;
        else if (cnt[wb_chan] == 16'hFFFF)  cnt_next = 16'hFFFF;
        else                                cnt_next = cnt[wb_chan] + 16'd1;
    end

    // A channel stays busy until its own writeback, so a set and a clear of
    // the same busy bit can never land on the same edge.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            busy <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                acc[c] <= FP_POS_ZERO;
                cnt[c] <= 16'd0;
            end
            out_pending <= 1'b0;
            pend_chan   <= '0;
            pend_data   <= FP_POS_ZERO;
            pend_count  <= 16'd0;
            validOut    <= 1'b0;
            chanOut     <= '0;
            dataOut     <= FP_POS_ZERO;
            countOut    <= 16'd0;
        end else begin
            if (accept) begin
                busy[chanIn] <= 1'b1;
            end
            if (res_valid) begin
                busy[wb_chan] <= 1'b0;
                acc[wb_chan]  <= res_data;
                cnt[wb_chan]  <= cnt_next;
            end

            out_pending <= res_valid && wb_last;
            if (res_valid && wb_last) begin
                pend_chan  <= wb_chan;
                pend_data  <= res_data;
                pend_count <= cnt_next;
            end

            // result fields only move on a pulse so they hold between results
            validOut <= out_pending;
            if (out_pending) begin
                chanOut  <= pend_chan;
                dataOut  <= pend_data;
                countOut <= pend_count;
            end
        end
    end

endmodule

// File: tb/tb_fp_channel_accumulate.sv
// tb/tb_fp_channel_accumulate.sv - directed self-checking bench for fp_channel_accumulate
module tb_fp_channel_accumulate;

    localparam int NUM_CHANNELS = 4;
    localparam int ADD_LATENCY  = 3;

    logic        clkIn   = 1'b0;
    logic        rstIn   = 1'b1;
    logic        validIn = 1'b0;
    logic        startIn = 1'b0;
    logic        lastIn  = 1'b0;
    logic [1:0]  chanIn  = 2'd0;
    logic [31:0] dataIn  = 32'd0;
    logic        readyOut;
    logic        validOut;
    logic [1:0]  chanOut;
    logic [31:0] dataOut;
    logic [15:0] countOut;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [31:0] q_data[$];
    int          q_chan[$];
    int          q_count[$];
    int          q_cycle[$];

    fp_channel_accumulate #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .ADD_LATENCY  (ADD_LATENCY)
    ) dut (
        .clkIn    (clkIn),
        .rstIn    (rstIn),
        .validIn  (validIn),
        .readyOut (readyOut),
        .startIn  (startIn),
        .lastIn   (lastIn),
        .chanIn   (chanIn),
        .dataIn   (dataIn),
        .validOut (validOut),
        .chanOut  (chanOut),
        .dataOut  (dataOut),
        .countOut (countOut)
    );

    always #5 clkIn = ~clkIn;

    always @(posedge clkIn) cycle <= cycle + 1;

    always @(negedge clkIn) begin
        if (validOut === 1'b1) begin
            q_data.push_back(dataOut);
            q_chan.push_back(int'(chanOut));
            q_count.push_back(int'(countOut));
            q_cycle.push_back(cycle);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // small positive integer to fp32 bits
    function automatic logic [31:0] int_fp(input int n);
        int e = 0;
        while ((n >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((n << (23 - e)) & 32'h007F_FFFF)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clkIn);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_chan.delete();
        q_count.delete();
        q_cycle.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int ch, input logic [31:0] d, input logic s, input logic l,
                        output int acc_cycle, output int stalls);
        validIn = 1'b1;
        chanIn  = 2'(ch);
        dataIn  = d;
        startIn = s;
        lastIn  = l;
        stalls  = 0;
        acc_cycle = -1;
        @(negedge clkIn);
        while (readyOut !== 1'b1 && stalls < 50) begin
            stalls++;
            @(negedge clkIn);
        end
        if (stalls >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout ch=%0d readyOut stayed low", ch);
            validIn = 1'b0;
            tick(1);
        end else begin
            @(posedge clkIn);
            #1;
            acc_cycle = cycle;
            validIn   = 1'b0;
        end
    endtask

    task automatic wait_results(input int n, input string name);
        int k = 0;
        while (q_data.size() < n && k < 40) begin
            tick(1);
            k++;
        end
        checks++;
        if (q_data.size() < n) begin
            failures++;
            $display("FAIL %s_wait results=%0d required=%0d", name, q_data.size(), n);
        end
    endtask

    task automatic test_reset();
        rstIn = 1'b1;
        tick(3);
        checks++; if (readyOut !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", readyOut); end
        checks++; if (validOut !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", validOut); end
        checks++; if (dataOut !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", dataOut); end
        checks++; if (chanOut !== 2'd0) begin failures++; $display("FAIL reset_chan got=%0d exp=0", chanOut); end
        checks++; if (countOut !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", countOut); end
        rstIn = 1'b0;
        tick(1);
    endtask

    task automatic test_single_channel();
        int acc_c, st;
        clear_q();
        for (int i = 1; i <= 16; i++) send(0, int_fp(i), i == 1, i == 16, acc_c, st);
        wait_results(1, "single");
        tick(8);
        checks++; if (q_data.size() != 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", q_data.size()); end
        checks++; if (q_data[0] !== 32'h4308_0000) begin failures++; $display("FAIL single_data got=%h exp=43080000", q_data[0]); end
        checks++; if (q_count[0] != 16) begin failures++; $display("FAIL single_count got=%0d exp=16", q_count[0]); end
        checks++; if (q_chan[0] != 0) begin failures++; $display("FAIL single_chan got=%0d exp=0", q_chan[0]); end
        checks++; if (q_cycle[0] - acc_c != ADD_LATENCY + 1) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", q_cycle[0] - acc_c, ADD_LATENCY + 1); end
    endtask

    task automatic test_neg_zero();
        int acc_c, st;
        clear_q();
        send(2, 32'h8000_0000, 1'b1, 1'b1, acc_c, st);
        wait_results(1, "negzero");
        tick(2);
        checks++; if (q_data[0] !== 32'h8000_0000) begin failures++; $display("FAIL negzero_data got=%h exp=80000000", q_data[0]); end
        checks++; if (q_count[0] != 1) begin failures++; $display("FAIL negzero_count got=%0d exp=1", q_count[0]); end
        checks++; if (q_chan[0] != 2) begin failures++; $display("FAIL negzero_chan got=%0d exp=2", q_chan[0]); end
        checks++; if (q_cycle[0] - acc_c != 4) begin failures++; $display("FAIL negzero_latency got=%0d exp=4", q_cycle[0] - acc_c); end
    endtask

    task automatic test_round_robin();
        int acc_c, st, first_acc, stall_sum;
        logic [31:0] exp_rr [4];
        exp_rr    = '{32'h4100_0000, 32'h4180_0000, 32'h41C0_0000, 32'h4200_0000};
        stall_sum = 0;
        first_acc = 0;
        clear_q();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 4; c++) begin
                send(c, int_fp(c + 1), r == 0, r == 7, acc_c, st);
                if (r == 0 && c == 0) first_acc = acc_c;
                stall_sum += st;
            end
        end
        checks++; if (stall_sum != 0) begin failures++; $display("FAIL rr_stalls got=%0d exp=0", stall_sum); end
        checks++; if (acc_c - first_acc != 31) begin failures++; $display("FAIL rr_throughput got=%0d exp=31", acc_c - first_acc); end
        wait_results(4, "rr");
        tick(3);
        checks++; if (q_data.size() != 4) begin failures++; $display("FAIL rr_pulses got=%0d exp=4", q_data.size()); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (q_chan[c] != c) begin failures++; $display("FAIL rr_chan idx=%0d got=%0d exp=%0d", c, q_chan[c], c); end
            checks++; if (q_data[c] !== exp_rr[c]) begin failures++; $display("FAIL rr_data ch=%0d got=%h exp=%h", c, q_data[c], exp_rr[c]); end
            checks++; if (q_count[c] != 8) begin failures++; $display("FAIL rr_count ch=%0d got=%0d exp=8", c, q_count[c]); end
        end
    endtask

    task automatic test_back_to_back();
        int acc_c, st, prev_acc;
        prev_acc = 0;
        clear_q();
        for (int i = 0; i < 4; i++) begin
            send(1, 32'h4000_0000, i == 0, i == 3, acc_c, st);
            if (i > 0) begin
                checks++; if (st != ADD_LATENCY) begin failures++; $display("FAIL b2b_ready_low i=%0d got=%0d exp=%0d", i, st, ADD_LATENCY); end
                checks++; if (acc_c - prev_acc != ADD_LATENCY + 1) begin failures++; $display("FAIL b2b_gap i=%0d got=%0d exp=%0d", i, acc_c - prev_acc, ADD_LATENCY + 1); end
            end
            prev_acc = acc_c;
        end
        wait_results(1, "b2b");
        tick(1);
        checks++; if (q_data[0] !== 32'h4100_0000) begin failures++; $display("FAIL b2b_data got=%h exp=41000000", q_data[0]); end
        checks++; if (q_count[0] != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", q_count[0]); end
        tick(5);
        checks++; if (validOut !== 1'b0) begin failures++; $display("FAIL hold_valid got=%b exp=0", validOut); end
        checks++; if (dataOut !== 32'h4100_0000) begin failures++; $display("FAIL hold_data got=%h exp=41000000", dataOut); end
        checks++; if (countOut !== 16'd4) begin failures++; $display("FAIL hold_count got=%0d exp=4", countOut); end
        checks++; if (chanOut !== 2'd1) begin failures++; $display("FAIL hold_chan got=%0d exp=1", chanOut); end
    endtask

    task automatic test_rounding();
        int acc_c, st;
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic [31:0] ve [7];
        va = '{32'h3F80_0000, 32'h3F80_0001, 32'h3F80_0000, 32'h0000_0001, 32'h4B80_0000, 32'h7F7F_FFFF, 32'h007F_FFFF};
        vb = '{32'h3380_0000, 32'h3380_0000, 32'hBF80_0000, 32'h0000_0001, 32'h4040_0000, 32'h7F7F_FFFF, 32'h0000_0001};
        ve = '{32'h3F80_0000, 32'h3F80_0002, 32'h0000_0000, 32'h0000_0002, 32'h4B80_0002, 32'h7F80_0000, 32'h0080_0000};
        for (int i = 0; i < 7; i++) begin
            clear_q();
            send(i % 4, va[i], 1'b1, 1'b0, acc_c, st);
            send(i % 4, vb[i], 1'b0, 1'b1, acc_c, st);
            wait_results(1, "round");
            tick(1);
            checks++; if (q_data[0] !== ve[i]) begin failures++; $display("FAIL round_data v=%0d got=%h exp=%h", i, q_data[0], ve[i]); end
            checks++; if (q_count[0] != 2) begin failures++; $display("FAIL round_count v=%0d got=%0d exp=2", i, q_count[0]); end
        end
    endtask

    task automatic test_reset_mid();
        int acc_c, st;
        clear_q();
        send(0, int_fp(1), 1'b1, 1'b0, acc_c, st);
        tick(4);
        send(0, int_fp(1), 1'b0, 1'b1, acc_c, st);
        send(1, int_fp(1), 1'b1, 1'b1, acc_c, st);
        rstIn = 1'b1;
        tick(2);
        rstIn = 1'b0;
        tick(10);
        checks++; if (q_data.size() != 0) begin failures++; $display("FAIL rstmid_no_output got=%0d exp=0", q_data.size()); end
        checks++; if (readyOut !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", readyOut); end
        send(0, int_fp(2), 1'b1, 1'b1, acc_c, st);
        wait_results(1, "rstmid");
        tick(1);
        checks++; if (q_data[0] !== 32'h4000_0000) begin failures++; $display("FAIL rstmid_data got=%h exp=40000000", q_data[0]); end
        checks++; if (q_count[0] != 1) begin failures++; $display("FAIL rstmid_count got=%0d exp=1", q_count[0]); end
        clear_q();
        send(1, int_fp(3), 1'b0, 1'b1, acc_c, st);
        wait_results(1, "nostart");
        tick(1);
        checks++; if (q_data[0] !== 32'h4040_0000) begin failures++; $display("FAIL nostart_data got=%h exp=40400000", q_data[0]); end
        checks++; if (q_count[0] != 1) begin failures++; $display("FAIL nostart_count got=%0d exp=1", q_count[0]); end
    endtask

    task automatic test_restart();
        int acc_c, st;
        clear_q();
        send(3, int_fp(5), 1'b1, 1'b0, acc_c, st);
        send(3, int_fp(1), 1'b0, 1'b0, acc_c, st);
        send(3, int_fp(3), 1'b1, 1'b1, acc_c, st);
        wait_results(1, "restart");
        tick(8);
        checks++; if (q_data.size() != 1) begin failures++; $display("FAIL restart_pulses got=%0d exp=1", q_data.size()); end
        checks++; if (q_data[0] !== 32'h4040_0000) begin failures++; $display("FAIL restart_data got=%h exp=40400000", q_data[0]); end
        checks++; if (q_count[0] != 1) begin failures++; $display("FAIL restart_count got=%0d exp=1", q_count[0]); end
        checks++; if (q_chan[0] != 3) begin failures++; $display("FAIL restart_chan got=%0d exp=3", q_chan[0]); end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_neg_zero();
        test_round_robin();
        test_back_to_back();
        test_rounding();
        test_reset_mid();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
